// File: rtl/io_sink_pkg.sv
// Shared types and default parameters for the IO result sink.
//   sink_state_t : run-control FSM states
//   Def*         : default values for the io_result_sink parameters
package io_sink_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} sink_state_t;

  localparam int unsigned DefDataWidth = 25;
  localparam int unsigned DefDepth     = 8;
  localparam int unsigned DefExpected  = 16;
  localparam int unsigned DefTimeout   = 1024;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and word; caller must not push when full unless popping
//   i_pop          : read strobe; caller must not pop when empty
//   o_full/o_empty : occupancy flags
//   o_head         : word at the read pointer, straight from registers
module sync_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  // Extra MSB on each pointer tells full from empty when the index bits match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PtrOne;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

endmodule

// File: rtl/io_result_sink.sv
// Host-side endpoint of the CPU IO channel: launches a run, captures result words into a FIFO
// and ends the run on an expected word count or an inactivity timeout.
//   clock, reset      : clock, asynchronous active-low reset
//   go                : run request (honoured in IDLE/DONE)
//   startIO           : one-cycle start pulse to the CPU
//   outFlagIOWB, out  : CPU result strobe and word
//   rd_valid/ready/data : FIFO drain port (first-word fall-through)
//   busy, done        : run status
//   overflow          : sticky, a word was dropped on a full FIFO this run
//   timed_out         : sticky, the last run ended by timeout
//   word_count        : words seen this run, dropped ones included
module io_result_sink
  import io_sink_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefDataWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned EXPECTED  = DefExpected,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         go,
  output logic                         startIO,
  input  logic                         outFlagIOWB,
  input  logic [DATAWIDTH-1:0]         out,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATAWIDTH-1:0]         rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         timed_out,
  output logic [$clog2(EXPECTED+1)-1:0] word_count
);

  localparam int unsigned CntW  = $clog2(EXPECTED + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0]  CntOne  = 1;
  localparam logic [IdleW-1:0] IdleOne = 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(EXPECTED - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT - 1);

  sink_state_t    r_state;
  sink_state_t    w_state_next;
  logic [CntW-1:0]  r_word_count;
  logic [IdleW-1:0] r_idle_cnt;
  logic             r_overflow;
  logic             r_timed_out;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_capture;
  logic w_last;
  logic w_expire;
  logic w_enter_start;

  assign w_capture     = (r_state == RUN) && outFlagIOWB;
  assign w_pop         = !w_empty && rd_ready;
  // A full FIFO still accepts the word when a slot frees up in the same cycle.
  assign w_push        = w_capture && (!w_full || w_pop);
  assign w_last        = w_capture && (r_word_count == CntLast);
  // A capture always wins over an expiring idle counter.
  assign w_expire      = !w_capture && (r_idle_cnt == IdleMax);
  assign w_enter_start = ((r_state == IDLE) || (r_state == DONE)) && go;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (go) w_state_next = START;
      START:   w_state_next = RUN;
      RUN:     if (w_last || w_expire) w_state_next = DONE;
      DONE:    if (go) w_state_next = START;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_word_count <= '0;
      r_idle_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_enter_start) begin
        r_word_count <= '0;
        r_idle_cnt   <= '0;
        r_overflow   <= 1'b0;
        r_timed_out  <= 1'b0;
      end else if (r_state == RUN) begin
        if (w_capture) begin
          r_word_count <= r_word_count + CntOne;
          r_idle_cnt   <= '0;
          if (w_full && !w_pop) begin
            r_overflow <= 1'b1;
          end
        end else if (w_expire) begin
          r_timed_out <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + IdleOne;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (out),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (rd_data)
  );

  assign rd_valid   = !w_empty;
  assign startIO    = (r_state == START);
  assign busy       = (r_state == START) || (r_state == RUN);
  assign done       = (r_state == DONE);
  assign overflow   = r_overflow;
  assign timed_out  = r_timed_out;
  assign word_count = r_word_count;

endmodule
